mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum BUSY cycles to wait for dmem_ack before a bus error.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 EX_MEM_alu_result  in  32  effective address / ALU result.
REQ-005 EX_MEM_read2_data  in  32  store data.
REQ-006 EX_MEM_adder_result  in  32  PC+4 for link writeback.
REQ-007 EX_MEM_RD  in  5  destination register.
REQ-008 EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemRead  in  1 each  control.
REQ-009 EX_MEM_WDSel  in  3  writeback select, passed through.
REQ-010 EX_MEM_DMType  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned.
REQ-011 dmem_req, dmem_we  out  1 each  bus request, write enable.
REQ-012 dmem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-013 dmem_wdata  out  32  lane-replicated store data.
REQ-014 dmem_be  out  4  byte enables.
REQ-015 dmem_rdata  in  32; dmem_ack  in  1  read data and completion.
REQ-016 mem_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
REQ-017 mem_misalign, mem_buserr  out  1 each  one-cycle error pulses.
REQ-018 MEM_WB_alu_result, MEM_WB_mem_data, MEM_WB_adder_result  out  32; MEM_WB_RD  out  5; MEM_WB_RegWrite  out  1; MEM_WB_WDSel  out  3  registered MEM/WB outputs.

Function
REQ-019 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-020 Memory op = MemRead or MemWrite; non-memory op in IDLE passes EX_MEM fields to MEM_WB at next edge, mem_stall 0, one-cycle latency.
REQ-021 Misaligned: word with addr[1:0]!=0, half with addr[0]!=0; no bus access, mem_misalign 1 for that cycle, MEM_WB loads with RegWrite 0, no stall.
REQ-022 IDLE + aligned memory op: mem_stall 1 combinationally, next state BUSY; dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be registered at that edge and held stable through BUSY.
REQ-023 BUSY: mem_stall 1; dmem_ack 1 -> capture dmem_rdata, drop dmem_req at edge, go DONE.
REQ-024 BUSY timeout counter counts from 0; reaching TIMEOUT without ack -> drop req, mem_buserr pulse in DONE, MEM_WB RegWrite forced 0.
REQ-025 Ack in same cycle as terminal count: ack wins, no buserr.
REQ-026 DONE: mem_stall 0, MEM_WB loads result at edge, next state IDLE; minimum memory-op latency 3 cycles.
REQ-027 While mem_stall 1, MEM_WB loads a bubble: RegWrite 0, RD 0, others 0.
REQ-028 Store lanes: word be 1111; half be 0011<<(2*addr[1]), data {2{rs2[15:0]}}; byte be 0001<<addr[1:0], data {4{rs2[7:0]}}.
REQ-029 Load extract: half lane addr[1], byte lane addr[1:0]; sign- or zero-extend per DMType; loads drive be 1111, we 0.
REQ-030 dmem_ack in IDLE or DONE is ignored.
REQ-031 Unknown DMType (101-111) treated as word.

Reset
REQ-032 rst low: state IDLE, counter 0, all outputs and MEM_WB registers 0, dmem_req dropped immediately without waiting for clk.
REQ-033 Reset mid-BUSY abandons the transaction; a later ack is ignored.

Verification
REQ-034 LW addr 0x100, ack on 2nd BUSY cycle, rdata 0xDEADBEEF -> stall 3 cycles, MEM_WB_mem_data 0xDEADBEEF, RegWrite 1.
REQ-035 LB addr 0x103, rdata 0x80FF_FF00 -> mem_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x202, rs2 0x1234ABCD -> be 1100, wdata 0xABCDABCD, we 1, dmem_addr 0x200.
REQ-037 LW addr 0x101 -> mem_misalign 1 one cycle, no dmem_req, MEM_WB_RegWrite 0.
REQ-038 TIMEOUT=4, no ack -> req drops after 4 BUSY cycles, mem_buserr pulse, RegWrite 0; repeat with ack on 4th cycle -> no buserr.
REQ-039 rst low during BUSY -> dmem_req 0 asynchronously, state IDLE; late ack produces no MEM_WB write.

Source files
------------

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit_if
// Brief   : Data-memory request/response bus between the MEM stage and memory.
// Rev     : 1.0
// ============================================================================
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_rdata,
        output dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit
// Brief   : MEM stage: data-memory access FSM, lane steering and MEM/WB register.
// Rev     : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       EX_MEM_alu_result,
    input  logic [31:0]       EX_MEM_read2_data,
    input  logic [31:0]       EX_MEM_adder_result,
    input  logic [4:0]        EX_MEM_RD,
    input  logic              EX_MEM_RegWrite,
    input  logic              EX_MEM_MemWrite,
    input  logic              EX_MEM_MemRead,
    input  logic [2:0]        EX_MEM_WDSel,
    input  logic [2:0]        EX_MEM_DMType,
    mem_access_unit_if.master dmem,
    output logic              mem_stall,
    output logic              mem_misalign,
    output logic              mem_buserr,
    output logic [31:0]       MEM_WB_alu_result,
    output logic [31:0]       MEM_WB_mem_data,
    output logic [31:0]       MEM_WB_adder_result,
    output logic [4:0]        MEM_WB_RD,
    output logic              MEM_WB_RegWrite,
    output logic [2:0]        MEM_WB_WDSel
);

    localparam int                 C_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_CNT_W-1:0] C_TERM  = C_CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]         C_DT_HS = 3'b001;
    localparam logic [2:0]         C_DT_HU = 3'b010;
    localparam logic [2:0]         C_DT_BS = 3'b011;
    localparam logic [2:0]         C_DT_BU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_req;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic [C_CNT_W-1:0] r_cnt;
    logic [31:0]        r_rdata;
    logic [1:0]         r_lane;
    logic [2:0]         r_dmtype;
    logic               r_is_read;
    logic               r_timed_out;

    logic [31:0]        r_wb_alu;
    logic [31:0]        r_wb_mem;
    logic [31:0]        r_wb_adder;
    logic [4:0]         r_wb_rd;
    logic               r_wb_regwrite;
    logic [2:0]         r_wb_wdsel;

    logic               w_mem_op;
    logic               w_is_half;
    logic               w_is_byte;
    logic               w_is_word;
    logic               w_misaligned;
    logic               w_stall;
    logic               w_misalign;
    logic               w_buserr;
    logic               w_issue;
    logic               w_ack_take;
    logic               w_timeout;
    logic [3:0]         w_st_be;
    logic [31:0]        w_st_wdata;
    logic [15:0]        w_half_sel;
    logic [7:0]         w_byte_sel;
    logic [31:0]        w_load_ext;
    logic [31:0]        w_load_data;

    assign w_mem_op     = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign w_is_half    = (EX_MEM_DMType == C_DT_HS) || (EX_MEM_DMType == C_DT_HU);
    assign w_is_byte    = (EX_MEM_DMType == C_DT_BS) || (EX_MEM_DMType == C_DT_BU);
    assign w_is_word    = ~w_is_half & ~w_is_byte;
    assign w_misaligned = w_mem_op & ((w_is_word & (|EX_MEM_alu_result[1:0]))
                                    | (w_is_half & EX_MEM_alu_result[0]));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An ack arriving on the terminal count cycle takes priority over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_misalign  = 1'b0;
        w_buserr    = 1'b0;
        w_issue     = 1'b0;
        w_ack_take  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    if (w_misaligned) begin
                        w_misalign = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_issue     = 1'b1;
                        w_state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (dmem.dmem_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == C_TERM) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_buserr    = r_timed_out;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = EX_MEM_read2_data;
        if (w_is_half) begin
            w_st_be    = EX_MEM_alu_result[1] ? 4'b1100 : 4'b0011;
            w_st_wdata = {2{EX_MEM_read2_data[15:0]}};
        end else if (w_is_byte) begin
            w_st_be    = 4'b0001 << EX_MEM_alu_result[1:0];
            w_st_wdata = {4{EX_MEM_read2_data[7:0]}};
        end
    end

    // Lane and access type are latched at issue so extraction is independent of EX_MEM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_lane      <= '0;
            r_dmtype    <= '0;
            r_is_read   <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (w_issue) begin
            r_req       <= 1'b1;
            r_we        <= EX_MEM_MemWrite;
            r_addr      <= {EX_MEM_alu_result[31:2], 2'b00};
            r_wdata     <= EX_MEM_MemWrite ? w_st_wdata : 32'h0;
            r_be        <= EX_MEM_MemWrite ? w_st_be : 4'b1111;
            r_cnt       <= '0;
            r_lane      <= EX_MEM_alu_result[1:0];
            r_dmtype    <= EX_MEM_DMType;
            r_is_read   <= EX_MEM_MemRead & ~EX_MEM_MemWrite;
            r_timed_out <= 1'b0;
        end else if (w_ack_take) begin
            r_req   <= 1'b0;
            r_rdata <= dmem.dmem_rdata;
        end else if (w_timeout) begin
            r_req       <= 1'b0;
            r_timed_out <= 1'b1;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_half_sel = r_lane[1] ? r_rdata[31:16] : r_rdata[15:0];
        w_byte_sel = r_rdata[7:0];
        case (r_lane)
            2'd1:    w_byte_sel = r_rdata[15:8];
            2'd2:    w_byte_sel = r_rdata[23:16];
            2'd3:    w_byte_sel = r_rdata[31:24];
            default: w_byte_sel = r_rdata[7:0];
        endcase
        case (r_dmtype)
            C_DT_HS: w_load_ext = {{16{w_half_sel[15]}}, w_half_sel};
            C_DT_HU: w_load_ext = {16'h0, w_half_sel};
            C_DT_BS: w_load_ext = {{24{w_byte_sel[7]}}, w_byte_sel};
            C_DT_BU: w_load_ext = {24'h0, w_byte_sel};
            default: w_load_ext = r_rdata;
        endcase
        w_load_data = (r_is_read & ~r_timed_out) ? w_load_ext : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_alu      <= '0;
            r_wb_mem      <= '0;
            r_wb_adder    <= '0;
            r_wb_rd       <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_wdsel    <= '0;
        end else if (w_stall) begin
            r_wb_alu      <= '0;
            r_wb_mem      <= '0;
            r_wb_adder    <= '0;
            r_wb_rd       <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_wdsel    <= '0;
        end else begin
            r_wb_alu      <= EX_MEM_alu_result;
            r_wb_adder    <= EX_MEM_adder_result;
            r_wb_rd       <= EX_MEM_RD;
            r_wb_wdsel    <= EX_MEM_WDSel;
            if (r_state == S_DONE) begin
                r_wb_mem      <= w_load_data;
                r_wb_regwrite <= EX_MEM_RegWrite & ~r_timed_out;
            end else begin
                r_wb_mem      <= 32'h0;
                r_wb_regwrite <= EX_MEM_RegWrite & ~w_misalign;
            end
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_be    = r_be;

    assign mem_stall           = w_stall;
    assign mem_misalign        = w_misalign;
    assign mem_buserr          = w_buserr;
    assign MEM_WB_alu_result   = r_wb_alu;
    assign MEM_WB_mem_data     = r_wb_mem;
    assign MEM_WB_adder_result = r_wb_adder;
    assign MEM_WB_RD           = r_wb_rd;
    assign MEM_WB_RegWrite     = r_wb_regwrite;
    assign MEM_WB_WDSel        = r_wb_wdsel;

endmodule
`default_nettype wire
